mem_access_unit: RTL and testbench

- Memory stage directly downstream of decode/execute.
- Takes the ALU result as the effective address, plus the load/store type codes produced by decode.
- Runs a single outstanding request/response transaction on the 64-bit data-memory port.
- Returns the aligned, extended load data to writeback. Non-memory instructions pass the ALU result through with one-cycle latency.

---
 rtl/mem_access_unit_pkg.sv | 61 ++++++
 rtl/mem_access_unit_if.sv | 24 ++
 rtl/mem_lane_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 125 ++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access stage: decode type codes, FSM states,
// access sizes and small decode helpers.
package mem_access_unit_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    // Load/store codes must track the decode encodings exactly.
    localparam logic [2:0] LOAD_TYPE_NONE = 3'b000;
    localparam logic [2:0] LOAD_TYPE_LB   = 3'b001;
    localparam logic [2:0] LOAD_TYPE_LH   = 3'b010;
    localparam logic [2:0] LOAD_TYPE_LW   = 3'b011;
    localparam logic [2:0] LOAD_TYPE_LD   = 3'b100;
    localparam logic [2:0] LOAD_TYPE_LBU  = 3'b101;
    localparam logic [2:0] LOAD_TYPE_LHU  = 3'b110;
    localparam logic [2:0] LOAD_TYPE_LWU  = 3'b111;

    localparam logic [2:0] STORE_TYPE_NONE = 3'b000;
    localparam logic [2:0] STORE_TYPE_SB   = 3'b100;
    localparam logic [2:0] STORE_TYPE_SH   = 3'b101;
    localparam logic [2:0] STORE_TYPE_SW   = 3'b110;
    localparam logic [2:0] STORE_TYPE_SD   = 3'b111;

    localparam logic [1:0] MEM_STATE_IDLE = 2'd0;
    localparam logic [1:0] MEM_STATE_REQ  = 2'd1;
    localparam logic [1:0] MEM_STATE_RSP  = 2'd2;
    localparam logic [1:0] MEM_STATE_HOLD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = MEM_STATE_IDLE,
        ST_REQ  = MEM_STATE_REQ,
        ST_RSP  = MEM_STATE_RSP,
        ST_HOLD = MEM_STATE_HOLD
    } mem_state_e;

    // Encoded as log2(bytes) so a store code's low bits map straight across.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    function automatic mem_size_e op_size(input logic [2:0] load_type,
                                          input logic [2:0] store_type);
        if (store_type != STORE_TYPE_NONE)
            return mem_size_e'(store_type[1:0]);
        case (load_type)
            LOAD_TYPE_LB, LOAD_TYPE_LBU: return SIZE_B;
            LOAD_TYPE_LH, LOAD_TYPE_LHU: return SIZE_H;
            LOAD_TYPE_LW, LOAD_TYPE_LWU: return SIZE_W;
            default:                     return SIZE_D;
        endcase
    endfunction

    function automatic logic load_is_signed(input logic [2:0] load_type);
        return (load_type == LOAD_TYPE_LB) || (load_type == LOAD_TYPE_LH) ||
               (load_type == LOAD_TYPE_LW);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response port: the access unit is master, memory is slave.
interface mem_access_unit_if #(
    parameter int XLEN   = mem_access_unit_pkg::XLEN,
    parameter int STRB_W = XLEN / 8
);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [STRB_W-1:0] dmem_wstrb;
    logic              dmem_rsp_valid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane arithmetic for the memory stage: strobes, store shift, load
// extract/extend and alignment check. Purely combinational.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]        addr_lo,
    input  mem_size_e         size,
    input  logic              is_signed,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata_shifted,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);
    logic [5:0]        shamt;
    logic [3:0]        size_bytes;
    logic [2:0]        align_mask;
    logic [STRB_W-1:0] size_mask;
    logic [XLEN-1:0]   field;

    assign shamt      = {addr_lo, 3'b000};
    assign size_bytes = 4'd1 << size;
    // For a dword size_bytes[2:0] wraps to 0, so the subtraction yields 3'b111.
    assign align_mask = size_bytes[2:0] - 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_mask
            assign size_mask[gi] = (4'(gi) < size_bytes);
        end
    endgenerate

    assign wstrb         = size_mask << addr_lo;
    assign wdata_shifted = wdata << shamt;
    assign field         = rdata >> shamt;
    assign misaligned    = |(addr_lo & align_mask);

    always_comb begin
        load_data = field;
        case (size)
            SIZE_B:  load_data = {{(XLEN-8){is_signed & field[7]}},   field[7:0]};
            SIZE_H:  load_data = {{(XLEN-16){is_signed & field[15]}}, field[15:0]};
            SIZE_W:  load_data = {{(XLEN-32){is_signed & field[31]}}, field[31:0]};
            default: load_data = field;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: latches one instruction, runs a single request/response on the
// data-memory port, and holds the aligned result until writeback takes it.
module mem_access_unit #(
    parameter int XLEN   = mem_access_unit_pkg::XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [2:0]        in_load_type,
    input  logic [2:0]        in_store_type,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic              out_misaligned,
    mem_access_unit_if.master dmem
);
    import mem_access_unit_pkg::*;

    mem_state_e        state_reg, state_next;
    logic [XLEN-1:0]   addr_reg, wdata_reg, out_data_reg;
    logic [2:0]        load_type_reg, store_type_reg;
    logic              out_misaligned_reg;

    logic              in_idle, accept, live_no_mem, is_store;
    logic [2:0]        addr_lo_sel;
    mem_size_e         size_sel;
    logic [STRB_W-1:0] lane_wstrb;
    logic [XLEN-1:0]   lane_wdata, lane_load;
    logic              lane_misaligned;

    assign in_idle     = (state_reg == ST_IDLE);
    assign accept      = in_idle && in_valid;
    assign live_no_mem = (in_load_type == LOAD_TYPE_NONE) && (in_store_type == STORE_TYPE_NONE);
    assign is_store    = (store_type_reg != STORE_TYPE_NONE);

    // Live inputs feed the lane logic only in IDLE, where just the misaligned
    // flag is consumed; every shifted value is used later from the latches.
    assign addr_lo_sel = in_idle ? in_alu_result[2:0] : addr_reg[2:0];
    assign size_sel    = in_idle ? op_size(in_load_type, in_store_type)
                                 : op_size(load_type_reg, store_type_reg);

    mem_lane_align u_lane (
        .addr_lo       (addr_lo_sel),
        .size          (size_sel),
        .is_signed     (load_is_signed(load_type_reg)),
        .wdata         (wdata_reg),
        .rdata         (dmem.dmem_rdata),
        .wstrb         (lane_wstrb),
        .wdata_shifted (lane_wdata),
        .load_data     (lane_load),
        .misaligned    (lane_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid) state_next = (live_no_mem || lane_misaligned) ? ST_HOLD : ST_REQ;
            ST_REQ:  if (dmem.dmem_req_ready) state_next = ST_RSP;
            ST_RSP:  if (dmem.dmem_rsp_valid) state_next = ST_HOLD;
            ST_HOLD: if (out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg           <= '0;
            wdata_reg          <= '0;
            load_type_reg      <= '0;
            store_type_reg     <= '0;
            out_data_reg       <= '0;
            out_misaligned_reg <= 1'b0;
        end else begin
            if (accept) begin
                addr_reg       <= in_alu_result;
                wdata_reg      <= in_wdata;
                load_type_reg  <= in_load_type;
                store_type_reg <= in_store_type;
                if (live_no_mem) begin
                    out_data_reg       <= in_alu_result;
                    out_misaligned_reg <= 1'b0;
                end else if (lane_misaligned) begin
                    out_data_reg       <= '0;
                    out_misaligned_reg <= 1'b1;
                end
            end
            if (state_reg == ST_RSP && dmem.dmem_rsp_valid) begin
                out_data_reg       <= is_store ? '0 : lane_load;
                out_misaligned_reg <= 1'b0;
            end
            if (state_reg == ST_HOLD && out_ready) begin
                out_data_reg       <= '0;
                out_misaligned_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        in_ready            = in_idle;
        out_valid           = (state_reg == ST_HOLD);
        out_data            = out_data_reg;
        out_misaligned      = out_misaligned_reg;
        dmem.dmem_req_valid = 1'b0;
        dmem.dmem_we        = 1'b0;
        dmem.dmem_addr      = '0;
        dmem.dmem_wdata     = '0;
        dmem.dmem_wstrb     = '0;
        if (state_reg == ST_REQ) begin
            dmem.dmem_req_valid = 1'b1;
            dmem.dmem_we        = is_store;
            dmem.dmem_addr      = {addr_reg[XLEN-1:3], 3'b000};
            dmem.dmem_wdata     = is_store ? lane_wdata : '0;
            dmem.dmem_wstrb     = is_store ? lane_wstrb : '0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, passthrough,
// backpressure and reset mid-transaction, with hand-computed expectations.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_alu_result, in_wdata;
    logic [2:0]  in_load_type, in_store_type;
    logic        out_valid, out_ready, out_misaligned;
    logic [63:0] out_data;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_unit_if dmem_if ();

    mem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_alu_result  (in_alu_result),
        .in_wdata       (in_wdata),
        .in_load_type   (in_load_type),
        .in_store_type  (in_store_type),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_misaligned (out_misaligned),
        .dmem           (dmem_if)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic drive_accept(input logic [63:0] alu, input logic [63:0] wd,
                                input logic [2:0] lt, input logic [2:0] st);
        in_valid      = 1'b1;
        in_alu_result = alu;
        in_wdata      = wd;
        in_load_type  = lt;
        in_store_type = st;
        tick;
        // Scramble live inputs so any use of them after accept shows up.
        in_valid      = 1'b0;
        in_alu_result = 64'h5A5A_5A5A_5A5A_5A57;
        in_wdata      = 64'hA5A5_A5A5_A5A5_A5A5;
        in_load_type  = 3'b000;
        in_store_type = 3'b000;
    endtask

    task automatic mem_op(input string tag, input logic [63:0] alu, input logic [63:0] wd,
                          input logic [2:0] lt, input logic [2:0] st,
                          input int req_waits, input int rsp_waits, input logic [63:0] rdata,
                          input logic [63:0] exp_addr, input logic [63:0] exp_wdata,
                          input logic [7:0] exp_wstrb, input logic exp_we);
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        drive_accept(alu, wd, lt, st);
        for (int i = 0; i <= req_waits; i++) begin
            chk({tag, ".req_valid"}, 64'(dmem_if.dmem_req_valid), 64'd1);
            chk({tag, ".addr"},      dmem_if.dmem_addr, exp_addr);
            chk({tag, ".wdata"},     dmem_if.dmem_wdata, exp_wdata);
            chk({tag, ".wstrb"},     64'(dmem_if.dmem_wstrb), 64'(exp_wstrb));
            chk({tag, ".we"},        64'(dmem_if.dmem_we), 64'(exp_we));
            chk({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
            dmem_if.dmem_req_ready = (i == req_waits);
            tick;
        end
        dmem_if.dmem_req_ready = 1'b0;
        chk({tag, ".req_dropped"}, 64'(dmem_if.dmem_req_valid), 64'd0);
        for (int i = 0; i < rsp_waits; i++) begin
            chk({tag, ".no_out_yet"}, 64'(out_valid), 64'd0);
            tick;
        end
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = rdata;
        tick;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = 64'h0;
    endtask

    task automatic check_out(input string tag, input logic [63:0] exp_data, input logic exp_mis);
        chk({tag, ".out_valid"},      64'(out_valid), 64'd1);
        chk({tag, ".out_data"},       out_data, exp_data);
        chk({tag, ".out_misaligned"}, 64'(out_misaligned), 64'(exp_mis));
        $display("txn %-8s out_data=0x%h misaligned=%0d", tag, out_data, out_misaligned);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready_back"},  64'(in_ready), 64'd1);
    endtask

    task automatic mis_op(input string tag, input logic [63:0] alu,
                          input logic [2:0] lt, input logic [2:0] st);
        drive_accept(alu, 64'hFFFF_FFFF_FFFF_FFFF, lt, st);
        chk({tag, ".no_req"}, 64'(dmem_if.dmem_req_valid), 64'd0);
        check_out(tag, 64'h0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_alu_result = '0; in_wdata = '0;
        in_load_type = '0; in_store_type = '0; out_ready = 1'b0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = '0;
        repeat (2) tick;
        chk("rst.in_ready",  64'(in_ready), 64'd1);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        chk("rst.out_data",  out_data, 64'h0);
        chk("rst.dmem_addr", dmem_if.dmem_addr, 64'h0);
        rst_n = 1'b1;
        tick;

        // lb / lbu of byte 3 = 0x80, response after two wait cycles
        mem_op("lb", 64'h1003, 64'hFFFF_FFFF_FFFF_FFFF, LOAD_TYPE_LB, STORE_TYPE_NONE,
               0, 2, 64'h0000_0000_8000_0000, 64'h1000, 64'h0, 8'h00, 1'b0);
        check_out("lb", 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        mem_op("lbu", 64'h1003, 64'h0, LOAD_TYPE_LBU, STORE_TYPE_NONE,
               0, 2, 64'h0000_0000_8000_0000, 64'h1000, 64'h0, 8'h00, 1'b0);
        check_out("lbu", 64'h0000_0000_0000_0080, 1'b0);

        // sh with a nonzero load code: store takes priority
        mem_op("sh", 64'h2006, 64'h1234, LOAD_TYPE_LB, STORE_TYPE_SH,
               1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 64'h2000, 64'h1234_0000_0000_0000, 8'hC0, 1'b1);
        check_out("sh", 64'h0, 1'b0);

        mem_op("lh", 64'h5002, 64'h0, LOAD_TYPE_LH, STORE_TYPE_NONE,
               0, 0, 64'h0000_0000_8765_0000, 64'h5000, 64'h0, 8'h00, 1'b0);
        check_out("lh", 64'hFFFF_FFFF_FFFF_8765, 1'b0);
        mem_op("lw", 64'h5004, 64'h0, LOAD_TYPE_LW, STORE_TYPE_NONE,
               0, 1, 64'h89AB_CDEF_0000_0000, 64'h5000, 64'h0, 8'h00, 1'b0);
        check_out("lw", 64'hFFFF_FFFF_89AB_CDEF, 1'b0);
        mem_op("lwu", 64'h5004, 64'h0, LOAD_TYPE_LWU, STORE_TYPE_NONE,
               0, 1, 64'h89AB_CDEF_0000_0000, 64'h5000, 64'h0, 8'h00, 1'b0);
        check_out("lwu", 64'h0000_0000_89AB_CDEF, 1'b0);

        // sd under four cycles of request backpressure, then sb at lane 5
        mem_op("sd", 64'h4000, 64'h0123_4567_89AB_CDEF, LOAD_TYPE_NONE, STORE_TYPE_SD,
               4, 1, 64'h0, 64'h4000, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        check_out("sd", 64'h0, 1'b0);
        mem_op("sb", 64'h4005, 64'hAB, LOAD_TYPE_NONE, STORE_TYPE_SB,
               0, 0, 64'h0, 64'h4000, 64'h0000_AB00_0000_0000, 8'h20, 1'b1);
        check_out("sb", 64'h0, 1'b0);

        mis_op("lw_mis", 64'h3002, LOAD_TYPE_LW, STORE_TYPE_NONE);
        mis_op("sd_mis", 64'h7004, LOAD_TYPE_NONE, STORE_TYPE_SD);

        // passthrough with three cycles of writeback backpressure
        drive_accept(64'hDEAD, 64'h0, LOAD_TYPE_NONE, STORE_TYPE_NONE);
        chk("pass.no_req", 64'(dmem_if.dmem_req_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("pass.valid_held", 64'(out_valid), 64'd1);
            chk("pass.data_held",  out_data, 64'hDEAD);
            chk("pass.in_ready",   64'(in_ready), 64'd0);
            tick;
        end
        check_out("pass", 64'hDEAD, 1'b0);

        // reset while waiting for a response, then a stale response arrives
        drive_accept(64'h6000, 64'h0, LOAD_TYPE_LD, STORE_TYPE_NONE);
        dmem_if.dmem_req_ready = 1'b1;
        tick;
        dmem_if.dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid.in_ready",  64'(in_ready), 64'd1);
        chk("rstmid.req_valid", 64'(dmem_if.dmem_req_valid), 64'd0);
        chk("rstmid.out_valid", 64'(out_valid), 64'd0);
        tick;
        rst_n = 1'b1;
        dmem_if.dmem_rsp_valid = 1'b1;
        dmem_if.dmem_rdata     = 64'hBAD0_BAD0_BAD0_BAD0;
        tick;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = 64'h0;
        chk("late_rsp.out_valid", 64'(out_valid), 64'd0);
        chk("late_rsp.in_ready",  64'(in_ready), 64'd1);
        chk("late_rsp.out_data",  out_data, 64'h0);
        mem_op("ld", 64'h6008, 64'h0, LOAD_TYPE_LD, STORE_TYPE_NONE,
               0, 0, 64'h1122_3344_5566_7788, 64'h6008, 64'h0, 8'h00, 1'b0);
        check_out("ld", 64'h1122_3344_5566_7788, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
